// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and digit moduli for the BCD countdown timer
package timer_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE,
      RUNNING,
      PAUSED,
      EXPIRED
   } timer_state_t;

   localparam int DIGIT_MOD_LO = 10;
   localparam int DIGIT_MOD_HI = 6;

endpackage

// File: rtl/mod_down_counter.sv
// rtl/mod_down_counter.sv - one BCD digit counting down modulo MOD_VALUE with borrow out
module mod_down_counter
   import timer_pkg::*;
#(
   parameter int MOD_VALUE = DIGIT_MOD_LO
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  bcd_t load_digit,
   input  logic decrement,
   output bcd_t count,
   output logic borrow
);

   localparam bcd_t MAX_DIGIT = bcd_t'(MOD_VALUE - 1);

   assign borrow = decrement && (count == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 4'd0;
      end else if (load) begin
         // Out-of-range load digits clamp to the largest legal digit
         count <= (load_digit > MAX_DIGIT) ? MAX_DIGIT : load_digit;
      end else if (decrement) begin
         count <= (count == 4'd0) ? MAX_DIGIT : count - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable ss.hh BCD countdown timer with pause and expiry flag
module countdown_timer
   import timer_pkg::*;
#(
   parameter int TICK_DIV = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        start,
   input  logic        stop,
   output logic [15:0] count,
   output logic        running,
   output logic        done,
   output logic        expired_pulse
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESCALE_LAST = PW'(TICK_DIV - 1);

   timer_state_t  state;
   timer_state_t  state_next;
   logic [PW-1:0] prescaler;
   logic          tick;
   logic          decrement;
   logic [3:0]    digit_dec;
   logic [2:0]    borrow;
   logic          borrow_unused;
   bcd_t          digit [4];

   assign tick      = (state == RUNNING) && (prescaler == PRESCALE_LAST);
   // A stop arriving with the tick freezes the count for that cycle
   assign decrement = tick && !stop;
   assign digit_dec = {borrow, decrement};
   assign count     = {digit[3], digit[2], digit[1], digit[0]};

   for (genvar i = 0; i < 4; i++) begin : g_digit
      localparam int MODV = (i == 3) ? DIGIT_MOD_HI : DIGIT_MOD_LO;
      if (i < 3) begin : g_chain
         mod_down_counter #(.MOD_VALUE(MODV)) u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_value[4*i +: 4]),
            .decrement  (digit_dec[i]),
            .count      (digit[i]),
            .borrow     (borrow[i])
         );
      end else begin : g_top
         mod_down_counter #(.MOD_VALUE(MODV)) u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_value[4*i +: 4]),
            .decrement  (digit_dec[i]),
            .count      (digit[i]),
            .borrow     (borrow_unused)
         );
      end
   end

   always_comb begin
      state_next = state;
      if (load) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start && !stop && count != 16'h0000) state_next = RUNNING;
            RUNNING: begin
               if (stop)                           state_next = PAUSED;
               else if (tick && count == 16'h0001) state_next = EXPIRED;
            end
            PAUSED:  if (start && !stop) state_next = RUNNING;
            EXPIRED: state_next = EXPIRED;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         prescaler     <= '0;
         running       <= 1'b0;
         done          <= 1'b0;
         expired_pulse <= 1'b0;
      end else begin
         state         <= state_next;
         running       <= (state_next == RUNNING);
         done          <= (state_next == EXPIRED);
         expired_pulse <= (state_next == EXPIRED) && (state != EXPIRED);
         // Prescaler phase survives a pause so resume continues mid-tick
         if (load)
            prescaler <= '0;
         else if (state == RUNNING && !stop)
            prescaler <= tick ? '0 : prescaler + PW'(1);
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] load_value;
   logic        start;
   logic        stop;
   logic [15:0] count;
   logic        running;
   logic        done;
   logic        expired_pulse;

   int total = 0;
   int bad   = 0;

   countdown_timer #(.TICK_DIV(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .load_value    (load_value),
      .start         (start),
      .stop          (stop),
      .count         (count),
      .running       (running),
      .done          (done),
      .expired_pulse (expired_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1;
      load_value = v;
      tick();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_flags(input string tag, input logic r, input logic d, input logic p);
      chk({tag, "_running"}, {15'd0, running}, {15'd0, r});
      chk({tag, "_done"}, {15'd0, done}, {15'd0, d});
      chk({tag, "_pulse"}, {15'd0, expired_pulse}, {15'd0, p});
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; load_value = 16'h0000; start = 1'b0; stop = 1'b0;
      ticks(2);
      chk("rst_count", count, 16'h0000);
      chk_flags("rst", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // 1: reset mid-count
      do_load(16'h0005);
      do_start();
      chk("t1_run", {15'd0, running}, 16'h0001);
      ticks(6);
      chk("t1_count6", count, 16'h0004);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t1_count", count, 16'h0000);
      chk_flags("t1", 1'b0, 1'b0, 1'b0);
      tick();
      chk("t1_nopulse", {15'd0, expired_pulse}, 16'h0000);

      // 2: basic countdown to expiry
      do_load(16'h0003);
      do_start();
      ticks(3);
      chk("t2_c3", count, 16'h0003);
      tick();
      chk("t2_c4", count, 16'h0002);
      ticks(4);
      chk("t2_c8", count, 16'h0001);
      ticks(4);
      chk("t2_c12", count, 16'h0000);
      chk_flags("t2_exp", 1'b0, 1'b1, 1'b1);
      tick();
      chk_flags("t2_after", 1'b0, 1'b1, 1'b0);
      do_start();
      chk("t2_restart_count", count, 16'h0000);
      chk_flags("t2_restart", 1'b0, 1'b1, 1'b0);

      // 3: borrow chain
      do_load(16'h1000);
      do_start();
      ticks(4);
      chk("t3_1000", count, 16'h0999);
      do_load(16'h5000);
      do_start();
      ticks(4);
      chk("t3_5000", count, 16'h4999);
      do_load(16'h0100);
      do_start();
      ticks(4);
      chk("t3_0100", count, 16'h0099);

      // 4: saturation and start at zero
      do_load(16'hFAC7);
      chk("t4_sat", count, 16'h5997);
      do_load(16'h0000);
      do_start();
      chk_flags("t4_zero", 1'b0, 1'b0, 1'b0);
      ticks(5);
      chk("t4_zero_count", count, 16'h0000);

      // 5: pause and resume keep prescaler phase
      do_load(16'h0002);
      do_start();
      ticks(2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t5_paused_run", {15'd0, running}, 16'h0000);
      ticks(20);
      chk("t5_hold", count, 16'h0002);
      chk("t5_hold_run", {15'd0, running}, 16'h0000);
      do_start();
      chk("t5_resume_run", {15'd0, running}, 16'h0001);
      tick();
      chk("t5_pre", count, 16'h0002);
      tick();
      chk("t5_dec", count, 16'h0001);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("t5_both_run", {15'd0, running}, 16'h0000);
      ticks(6);
      chk("t5_both_count", count, 16'h0001);

      // 6: priority cases
      load = 1'b1; load_value = 16'h0001; start = 1'b1;
      tick();
      load = 1'b0; start = 1'b0;
      chk("t6_ldst_count", count, 16'h0001);
      chk("t6_ldst_run", {15'd0, running}, 16'h0000);
      ticks(5);
      chk("t6_ldst_idle", count, 16'h0001);
      do_start();
      ticks(3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t6_stopfinal_count", count, 16'h0001);
      chk_flags("t6_stopfinal", 1'b0, 1'b0, 1'b0);
      do_start();
      tick();
      chk("t6_exp_count", count, 16'h0000);
      chk_flags("t6_exp", 1'b0, 1'b1, 1'b1);
      ticks(2);
      do_load(16'h0042);
      chk("t6_reload", count, 16'h0042);
      chk_flags("t6_reload", 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
